// File: rtl/im_pipelined.sv
// Parametrised instruction memory: byte-enable writes, valid/ready requests,
// a pipelined read path with an out-of-range error flag, and a post-reset clear sweep.
module im_pipelined #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 10,
  parameter int DEPTH        = 1024,
  parameter int RD_LAT       = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  input  logic [DATA_W/8-1:0]   req_be,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  err,
  output logic                  busy
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

  if (DATA_W % 8 != 0) begin : g_bad_data_w
    $error("im_pipelined: DATA_W must be a multiple of 8");
  end
  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
    $error("im_pipelined: RD_LAT must be in 1..4");
  end
  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("im_pipelined: DEPTH must be in 1..2**ADDR_W");
  end

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
      ptr   <= '0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    ptr_nx    = ptr;
    busy      = 1'b0;
    req_ready = 1'b0;
    case (state)
      S_CLEAR: begin
        busy = 1'b1;
        if (ptr == LAST) begin
          ptr_nx   = '0;
          state_nx = S_RUN;
        end else begin
          ptr_nx = ptr + 1'b1;
        end
      end
      S_RUN:   req_ready = 1'b1;
      default: state_nx = S_RUN;
    endcase
  end

  logic             acc, in_range;
  logic [IDX_W-1:0] idx;

  // Range check is done on the full address so nothing >= DEPTH can alias.
  assign acc      = req_valid && req_ready;
  assign in_range = {1'b0, req_addr} < (ADDR_W+1)'(DEPTH);
  assign idx      = req_addr[IDX_W-1:0];

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[ptr] <= '0;
      end else if (acc && req_write && in_range) begin
        for (int b = 0; b < NB; b++)
          if (req_be[b]) mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
      end
    end
  end

  logic              vld0, err0;
  logic [DATA_W-1:0] dat0;

  assign vld0 = acc && !req_write;
  assign err0 = acc && !in_range;
  assign dat0 = in_range ? mem[idx] : '0;

  logic [RD_LAT:1]   vld_pipe, err_pipe;
  logic [DATA_W-1:0] dat_pipe [1:RD_LAT];

  // The last data stage only loads on a valid read, so rd_data holds between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      err_pipe <= '0;
      for (int j = 1; j <= RD_LAT; j++) dat_pipe[j] <= '0;
    end else begin
      vld_pipe[1] <= vld0;
      err_pipe[1] <= err0;
      if (RD_LAT > 1 || vld0) dat_pipe[1] <= dat0;
      for (int j = 2; j <= RD_LAT; j++) begin
        vld_pipe[j] <= vld_pipe[j-1];
        err_pipe[j] <= err_pipe[j-1];
        if (j < RD_LAT || vld_pipe[j-1]) dat_pipe[j] <= dat_pipe[j-1];
      end
    end
  end

  assign rd_valid = vld_pipe[RD_LAT];
  assign err      = err_pipe[RD_LAT];
  assign rd_data  = dat_pipe[RD_LAT];

endmodule
